data_mem_responder: RTL and testbench

//  Memory-side responder for load/store requests issued by the core datapath over a valid/ready request channel.

---
 rtl/data_mem_responder_if.sv | 28 ++
 rtl/data_mem_responder.sv | 176 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the core datapath (master) and the data memory responder (slave).
//   req_valid/req_ready  request handshake; req_we, req_size, req_unsigned, req_addr, req_wdata
//                        describe the access
//   rsp_valid/rsp_ready  response handshake; rsp_rdata carries extended load data,
//                        rsp_err flags a rejected access
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering load/store requests with programmable wait states.
// Byte/half/word lanes are little-endian; loads are sign- or zero-extended.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (RAM contents are not reset)
//   bus    data_mem_responder_if.slave: request channel in, response channel out
// Build option:
//   DMEM_MISALIGN_TRAP_EN  defined: misaligned half/word accesses return rsp_err.
//                          undefined: low address bits are forced aligned instead.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst_n,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);
  localparam logic [33:0] SpanB    = 34'(DEPTH_WORDS) * 34'd4;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        accept, commit;

  logic [31:0] mem [DEPTH_WORDS];

  // Access fields: live request when committing on the accepting edge (no wait states),
  // otherwise the fields latched at accept.
  logic        a_we, a_uns;
  logic [1:0]  a_size;
  logic [31:0] a_addr, a_wdata;

  always_comb begin
    if (state_q == StIdle) begin
      a_we    = bus.req_we;
      a_uns   = bus.req_unsigned;
      a_size  = bus.req_size;
      a_addr  = bus.req_addr;
      a_wdata = bus.req_wdata;
    end else begin
      a_we    = we_q;
      a_uns   = uns_q;
      a_size  = size_q;
      a_addr  = addr_q;
      a_wdata = wdata_q;
    end
  end

  // Address decode, range and legality checks.
  logic [31:0]     eff_addr, off;
  logic            misalign, in_range, acc_err;
  logic [IdxW-1:0] idx;
  logic [4:0]      sh;

  always_comb begin
    eff_addr = a_addr;
    misalign = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    misalign = ((a_size == 2'b01) && a_addr[0]) || ((a_size == 2'b10) && (a_addr[1:0] != 2'b00));
`else
    if (a_size == 2'b01) eff_addr[0] = 1'b0;
    if (a_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
    off      = eff_addr - BASE_ADDR;
    // A wrap below BASE_ADDR yields a huge offset, but the explicit compare keeps it out of range.
    in_range = (eff_addr >= BASE_ADDR) && ({2'b00, off} < SpanB);
    acc_err  = !in_range || (a_size == 2'b11) || misalign;
    idx      = off[IdxW+1:2];
    sh       = {eff_addr[1:0], 3'b000};
  end

  // Lane select / extend for loads, read-modify-write word for stores.
  logic [31:0] cur_word, shifted, load_data, lane_mask, wr_word;

  always_comb begin
    cur_word = mem[idx];
    shifted  = cur_word >> sh;
    unique case (a_size)
      2'b00: begin
        load_data = a_uns ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF;
      end
      2'b01: begin
        load_data = a_uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF;
      end
      default: begin
        load_data = cur_word;
        lane_mask = 32'hFFFF_FFFF;
      end
    endcase
    wr_word = (cur_word & ~(lane_mask << sh)) | ((a_wdata << sh) & (lane_mask << sh));
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          cnt_d  = WaitInit;
          if (WAIT_STATES == 0) begin
            commit  = 1'b1;
            state_d = StResp;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          commit  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        size_q  <= bus.req_size;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
      end
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (acc_err || a_we) ? 32'h0 : load_data;
      end
    end
  end

  // rst_n gating keeps a zero-wait-state store from landing while reset is held.
  always_ff @(posedge clk) begin
    if (commit && a_we && !acc_err && rst_n) mem[idx] <= wr_word;
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: byte-level reference memory predicts each
// response, predictions are queued at issue and compared when the response appears.
module tb_data_mem_responder;
  localparam int unsigned WS    = 2;
  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_WORDS(DEPTH),
    .WAIT_STATES(WS),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  logic [7:0] ref_mem [4*DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference model: byte-addressed, updates ref_mem for accepted stores.
  task automatic predict(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output exp_t e);
    logic [31:0] a, off, v;
    logic        mis;
    int          nb;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    nb  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    a   = addr;
    mis = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (size != 2'b11) && ((addr & 32'(nb - 1)) != 32'h0);
`else
    a = addr & ~32'(nb - 1);
`endif
    off = a - BASE;
    if (size == 2'b11 || a < BASE || off >= 32'(4 * DEPTH) || mis) begin
      e.err = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < nb; i++) ref_mem[off + 32'(i)] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[off + 32'(i)];
      if (!uns && nb < 4 && v[8*nb-1]) begin
        for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
      end
      e.rdata = v;
    end
  endtask

  // Issue one request, check latency, response, backpressure stability and return to idle.
  task automatic transact(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold);
    exp_t e, x;
    int   n;
    predict(we, size, uns, addr, wdata, e);
    sb_q.push_back(e);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " req_ready before accept"}, 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    // Scramble request fields after accept: they must be ignored outside idle.
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_size  = 2'($urandom_range(0, 3));
    n = 1;
    while (!bus.rsp_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(WS + 1));
    x = sb_q.pop_front();
    check({tag, " rdata"}, bus.rsp_rdata, x.rdata);
    check({tag, " err"}, 32'(bus.rsp_err), 32'(x.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " held valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, " held rdata"}, bus.rsp_rdata, x.rdata);
      check({tag, " held err"}, 32'(bus.rsp_err), 32'(x.err));
      check({tag, " held req_ready"}, 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check({tag, " idle rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, " idle req_ready"}, 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4 * int'(DEPTH); i++) ref_mem[i] = 8'h00;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset req_ready", 32'(bus.req_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge clk); #1;

    // Populate a known window and the top word.
    for (int i = 0; i < 16; i++) begin
      transact("init", 1'b1, 2'b10, 1'b0, 32'(4 * i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 0);
    end
    transact("init top", 1'b1, 2'b10, 1'b0, 32'h3FC, 32'h5A5A_1234, 0);

    transact("st word", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 0);
    transact("ld word", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    transact("st byte", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080, 0);
    transact("ld byte s", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 0);
    transact("ld byte u", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 0);
    transact("ld word2", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 0);
    transact("st half", 1'b1, 2'b01, 1'b0, 32'h16, 32'h0000_9ABC, 0);
    transact("ld half s", 1'b0, 2'b01, 1'b0, 32'h16, 32'h0, 0);
    transact("ld half u", 1'b0, 2'b01, 1'b1, 32'h16, 32'h0, 0);

    transact("ld oor", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 0);
    transact("st oor", 1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5_A5A5, 0);
    transact("ld w0", 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0);
    transact("ld top", 1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, 0);
    transact("ld far", 1'b0, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0, 0);
    transact("ld size3", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 0);
    transact("st size3", 1'b1, 2'b11, 1'b0, 32'h14, 32'hFFFF_FFFF, 0);
    transact("ld w14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 0);

    transact("backpressure", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 5);
    transact("misalign w", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 0);
    transact("misalign h", 1'b0, 2'b01, 1'b1, 32'h13, 32'h0, 2);

    // Reset during the wait states of a store: the target word must stay unchanged.
    bus.req_we    = 1'b1;
    bus.req_size  = 2'b10;
    bus.req_addr  = 32'h20;
    bus.req_wdata = 32'h1234_5678;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    check("mid busy req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid rst req_ready", 32'(bus.req_ready), 32'd1);
    check("mid rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    transact("ld after rst", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 0);

    // Mixed traffic inside the populated window plus occasional out-of-range addresses.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'h400 + 32'($urandom_range(0, 255))
                                      : 32'($urandom_range(0, 63));
      transact("mix", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
